// File: rtl/csa_pkg.sv
// Shared types and width helpers for the streaming carry-save accumulator.
// Optional feature: CSA_ACC_SIGNED_EN (see csa_accumulator.sv).
package csa_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic int calc_acc_w(input int width, input int max_ops);
        return width + $clog2(max_ops);
    endfunction

    function automatic int calc_nchunk(input int acc_w, input int chunk);
        return (acc_w + chunk - 1) / chunk;
    endfunction

    function automatic int calc_cnt_w(input int max_ops);
        return $clog2(max_ops + 1);
    endfunction

    // Index width that stays at least one bit when there is a single chunk.
    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csa_row.sv
// Bitwise 3:2 compressor row: sum = a^b^c, carry = maj(a,b,c), carry left unshifted.
module csa_row #(
    parameter int W = 12
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_fa
            assign o_sum[gi]   = i_a[gi] ^ i_b[gi] ^ i_c[gi];
            assign o_carry[gi] = (i_a[gi] & i_b[gi]) | (i_a[gi] & i_c[gi]) | (i_b[gi] & i_c[gi]);
        end
    endgenerate

endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand accumulator: operands fold into a redundant S/C pair, then a
// chunked carry-propagate pass resolves the group. CSA_ACC_SIGNED_EN selects sign-extension.
module csa_accumulator
    import csa_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int MAX_OPS = 16,
    parameter  int CHUNK   = 4,
    localparam int ACC_W   = calc_acc_w(WIDTH, MAX_OPS),
    localparam int CNT_W   = calc_cnt_w(MAX_OPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam int NCHUNK = calc_nchunk(ACC_W, CHUNK);
    localparam int IDX_W  = calc_idx_w(NCHUNK);
    localparam int NSLOT  = 2 ** IDX_W;
    localparam int PAD_W  = NCHUNK * CHUNK;

    state_t             r_state;
    logic [ACC_W-1:0]   r_s;
    logic [ACC_W-1:0]   r_c;
    logic [CNT_W-1:0]   r_count;
    logic [IDX_W-1:0]   r_chunk;
    logic               r_carry;
    logic [CHUNK-1:0]   r_res [NSLOT];

    logic [ACC_W-1:0]   w_x;
    logic [ACC_W-1:0]   w_sum;
    logic [ACC_W-1:0]   w_maj;
    logic [ACC_W-1:0]   w_carry_sh;
    logic [CNT_W-1:0]   w_count_nx;
    logic               w_close;
    logic [PAD_W-1:0]   w_s_pad;
    logic [PAD_W-1:0]   w_c_pad;
    logic [PAD_W-1:0]   w_res_pad;
    logic [CHUNK-1:0]   w_s_chk [NSLOT];
    logic [CHUNK-1:0]   w_c_chk [NSLOT];
    logic [CHUNK:0]     w_chunk_sum;

`ifdef CSA_ACC_SIGNED_EN
    assign w_x = ACC_W'($signed(in_data));
`else
    assign w_x = ACC_W'(in_data);
`endif

    csa_row #(.W(ACC_W)) u_row (
        .i_a     (r_s),
        .i_b     (r_c),
        .i_c     (w_x),
        .o_sum   (w_sum),
        .o_carry (w_maj)
    );

    assign w_carry_sh = w_maj << 1;
    assign w_count_nx = r_count + 1'b1;
    assign w_close    = in_last || (w_count_nx == CNT_W'(MAX_OPS));

    always_comb begin
        w_s_pad = '0;
        w_c_pad = '0;
        w_s_pad[ACC_W-1:0] = r_s;
        w_c_pad[ACC_W-1:0] = r_c;
    end

    // Slots past NCHUNK read as zero so the chunk mux never indexes out of range.
    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < NCHUNK) begin : g_live
                assign w_s_chk[gi] = w_s_pad[gi*CHUNK +: CHUNK];
                assign w_c_chk[gi] = w_c_pad[gi*CHUNK +: CHUNK];
                assign w_res_pad[gi*CHUNK +: CHUNK] = r_res[gi];
            end else begin : g_pad
                assign w_s_chk[gi] = '0;
                assign w_c_chk[gi] = '0;
            end
        end
    endgenerate

    assign w_chunk_sum = {1'b0, w_s_chk[r_chunk]} + {1'b0, w_c_chk[r_chunk]}
                       + {{CHUNK{1'b0}}, r_carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
            r_s     <= '0;
            r_c     <= '0;
            r_count <= '0;
            r_chunk <= '0;
            r_carry <= 1'b0;
            for (int k = 0; k < NSLOT; k++) begin
                r_res[k] <= '0;
            end
        end else begin
            case (r_state)
                ACCUM: begin
                    if (in_valid) begin
                        r_s     <= w_sum;
                        r_c     <= w_carry_sh;
                        r_count <= w_count_nx;
                        if (w_close) begin
                            r_state <= RESOLVE;
                            r_chunk <= '0;
                            r_carry <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    r_res[r_chunk] <= w_chunk_sum[CHUNK-1:0];
                    r_carry        <= w_chunk_sum[CHUNK];
                    if (r_chunk == IDX_W'(NCHUNK - 1)) begin
                        r_state <= DONE;
                    end else begin
                        r_chunk <= r_chunk + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_s     <= '0;
                        r_c     <= '0;
                        r_count <= '0;
                        r_state <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == DONE);
    assign out_data  = w_res_pad[ACC_W-1:0];
    assign out_count = r_count;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator at default parameters; honours CSA_ACC_SIGNED_EN.
module tb_csa_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_data;
    logic [4:0]  out_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    always #5 clk = ~clk;

    csa_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one beat; it must be accepted on the next rising edge.
    task automatic beat(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        chk("beat_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        $display("beat data=0x%02h last=%0d", d, last);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk("wait_out_valid", out_valid, 1'b1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_hs_in_ready", in_ready, 1'b1);
        chk("post_hs_out_valid", out_valid, 1'b0);
    endtask

    task automatic result(input string tag, input logic [11:0] d, input logic [4:0] c);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_count"}, out_count, c);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        $display("result %s data=0x%03h count=%0d", tag, out_data, out_count);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 12'h000);
        chk("rst_out_count", out_count, 5'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 3 + 5 + 7, latency of exactly NCHUNK cycles after the closing edge
        beat(8'd3, 1'b0);
        beat(8'd5, 1'b0);
        beat(8'd7, 1'b1);
        chk("lat_c1_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("lat_c2_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("lat_c3_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("lat_c3_valid_hi", out_valid, 1'b1);
        result("sum357", 12'd15, 5'd3);
        handshake();

        // 16 x 0xFF without in_last closes on the 16th beat
        for (int i = 0; i < 16; i++) beat(8'hFF, 1'b0);
        chk("max_ops_in_ready_low", in_ready, 1'b0);
        wait_valid(cyc);
        chk("max_ops_latency", cyc, 3);
        result("max_ops", 12'hFF0, 5'd16);

        // Backpressure: result held while out_ready is low
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", out_data, 12'hFF0);
            chk("hold_count", out_count, 5'd16);
            chk("hold_in_ready", in_ready, 1'b0);
        end
        handshake();
        beat(8'd1, 1'b0);
        beat(8'd2, 1'b1);
        wait_valid(cyc);
        result("cleared", 12'd3, 5'd2);
        handshake();

        // in_last with in_valid low is ignored; single zero beat group
        in_last = 1'b1;
        idle(3);
        chk("ghost_last_in_ready", in_ready, 1'b1);
        in_last = 1'b0;
        beat(8'd0, 1'b1);
        wait_valid(cyc);
        result("single_zero", 12'd0, 5'd1);
        handshake();

        // Valid bubbles mid-group
        beat(8'd10, 1'b0);
        idle(3);
        beat(8'd20, 1'b0);
        idle(1);
        beat(8'd30, 1'b1);
        wait_valid(cyc);
        result("bubbles", 12'd60, 5'd3);
        handshake();

        // Asynchronous reset during RESOLVE aborts the group
        beat(8'd9, 1'b0);
        beat(8'd9, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_out_data", out_data, 12'd0);
        chk("abort_out_count", out_count, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready", in_ready, 1'b1);
        beat(8'd4, 1'b0);
        beat(8'd4, 1'b1);
        wait_valid(cyc);
        result("after_abort", 12'd8, 5'd2);
        handshake();

        // Sign handling
        beat(8'hFD, 1'b0);
        beat(8'h01, 1'b1);
        wait_valid(cyc);
`ifdef CSA_ACC_SIGNED_EN
        result("signed", 12'hFFE, 5'd2);
`else
        result("unsigned", 12'h0FE, 5'd2);
`endif
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
